// File: rtl/bus_pkg.sv
// Shared types and default sizing for the bus arbiter slice.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int DEF_NUM_MASTERS    = 3;
  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester after last_owner wins.
module rr_picker
  import bus_pkg::*;
#(
  parameter int N = DEF_NUM_MASTERS
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_owner,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int IW = $clog2(N);

  int cand;

  // Walk the ring starting one past the last owner; the first hit is the winner.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_owner) + k) % N;
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for NUM_MASTERS masters onto one slave port.
// Optional slave-wait timeout enabled by defining BUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests this cycle
// OWN   | owner's transfer presented on the bus; wait for bus_ready (or timeout)
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                                clk_sys,
  input  logic                                rst_n,
  input  logic [NUM_MASTERS-1:0]              m_req,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata,
  input  logic [NUM_MASTERS-1:0]              m_we,
  output logic [NUM_MASTERS-1:0]              m_grant,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic                                m_err,
  output logic                                bus_valid,
  output logic [ADDR_W-1:0]                   bus_addr,
  output logic [DATA_W-1:0]                   bus_wdata,
  output logic                                bus_we,
  input  logic                                bus_ready,
  input  logic [DATA_W-1:0]                   bus_rdata
);

  localparam int IW = $clog2(NUM_MASTERS);

  state_e                 state_q, state_d;
  logic [IW-1:0]          last_owner_q, last_owner_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   valid_q, valid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   tmo_hit;

  logic [NUM_MASTERS-1:0] req_eff;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  // The master just acked may still hold m_req this cycle; keep it out of the race.
  assign req_eff = m_req & ~ack_q;

  rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req        (req_eff),
    .last_owner (last_owner_q),
    .gnt        (pick_gnt),
    .gnt_idx    (pick_idx),
    .gnt_valid  (pick_valid)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;

  assign tmo_hit = (tmo_cnt_q == '0);
  assign m_err   = err_q;

  // Timeout down-counter and error flag registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign tmo_hit    = 1'b0;
  assign m_err      = 1'b0;
`endif

  // State and registered output flops.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= IW'(NUM_MASTERS - 1);
      grant_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
    end
  end

  // Next-state: claim the bus on any request, release on completion or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_valid) state_d = OWN;
      OWN:  if (bus_ready || tmo_hit) state_d = IDLE;
    endcase
  end

  // Output/datapath: latch the winner's bus signals at grant, finish the transfer on exit.
  always_comb begin
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
`ifdef BUS_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_owner_d = pick_idx;
          grant_d      = pick_gnt;
          valid_d      = 1'b1;
          addr_d       = m_addr[pick_idx];
          wdata_d      = m_wdata[pick_idx];
          we_d         = m_we[pick_idx];
`ifdef BUS_TIMEOUT_EN
          tmo_cnt_d    = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      OWN: begin
        if (bus_ready) begin
          ack_d   = grant_q;
          grant_d = '0;
          valid_d = 1'b0;
          if (!we_q) rdata_d = bus_rdata;
        end else if (tmo_hit) begin
          ack_d   = grant_q;
          grant_d = '0;
          valid_d = 1'b0;
          rdata_d = '1;
`ifdef BUS_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q - 1'b1;
`endif
        end
      end
    endcase
  end

  assign m_grant   = grant_q;
  assign m_ack     = ack_q;
  assign m_rdata   = rdata_q;
  assign bus_valid = valid_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (3 masters, 8-bit bus, TIMEOUT_CYCLES=8).
module tb_bus_arbiter;

  logic            clk_sys;
  logic            rst_n;
  logic [2:0]      m_req;
  logic [2:0][7:0] m_addr;
  logic [2:0][7:0] m_wdata;
  logic [2:0]      m_we;
  logic [2:0]      m_grant;
  logic [2:0]      m_ack;
  logic [7:0]      m_rdata;
  logic            m_err;
  logic            bus_valid;
  logic [7:0]      bus_addr;
  logic [7:0]      bus_wdata;
  logic            bus_we;
  logic            bus_ready;
  logic [7:0]      bus_rdata;

  bus_arbiter #(
    .NUM_MASTERS(3), .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_grant(m_grant), .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         m;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    int         delay;
    logic [7:0] sdata;
    logic       drop;
  } vec_t;

  typedef struct {
    logic [2:0] ack;
    logic [7:0] rdata;
    logic       err;
    int         own;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   own_cnt = 0;
  logic mon_en = 1'b0;
  logic [7:0] prev_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every ack pops one expectation.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (m_grant != 3'b000) own_cnt++;
      if (m_ack != 3'b000) begin
        if (sb.size() == 0) begin
          chk("spurious_ack", {29'd0, m_ack}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack",        {29'd0, m_ack},   {29'd0, e.ack});
          chk("rdata",      {24'd0, m_rdata}, {24'd0, e.rdata});
          chk("err",        {31'd0, m_err},   {31'd0, e.err});
          chk("own_cycles", own_cnt,          e.own);
        end
        own_cnt = 0;
      end
    end else begin
      own_cnt = 0;
    end
  end

  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (m_grant != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_xfer(input vec_t v);
    exp_t e;
    logic ok;
    logic [2:0] oh;
    oh = 3'b001 << v.m;
    if (!v.we) prev_rdata = v.sdata;
    e.ack = oh; e.rdata = prev_rdata; e.err = 1'b0; e.own = v.delay + 1;
    sb.push_back(e);
    m_req[v.m]   = 1'b1;
    m_addr[v.m]  = v.addr;
    m_wdata[v.m] = v.wdata;
    m_we[v.m]    = v.we;
    wait_grant(ok);
    chk("grant_wait", {31'd0, ok}, 32'd1);
    chk("grant",     {29'd0, m_grant},   {29'd0, oh});
    chk("bus_valid", {31'd0, bus_valid}, 32'd1);
    chk("bus_addr",  {24'd0, bus_addr},  {24'd0, v.addr});
    chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, v.wdata});
    chk("bus_we",    {31'd0, bus_we},    {31'd0, v.we});
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk_sys);
      if (v.drop && d == 0) m_req[v.m] = 1'b0;
    end
    bus_ready = 1'b1;
    bus_rdata = v.sdata;
    @(negedge clk_sys);
    bus_ready   = 1'b0;
    bus_rdata   = 8'h00;
    m_req[v.m]  = 1'b0;
    chk("grant_after_ack", {29'd0, m_grant}, 32'd0);
    chk("valid_after_ack", {31'd0, bus_valid}, 32'd0);
    @(negedge clk_sys);
  endtask

  vec_t vt[6];
  logic [2:0] gq[$];
  int         cq[$];
  logic       ok;

  initial begin
    vt[0] = '{m:1, addr:8'h10, wdata:8'h00, we:1'b0, delay:3, sdata:8'hA5, drop:1'b0};
    vt[1] = '{m:2, addr:8'h7F, wdata:8'h3C, we:1'b1, delay:1, sdata:8'h55, drop:1'b0};
    vt[2] = '{m:0, addr:8'h20, wdata:8'h11, we:1'b0, delay:0, sdata:8'h5A, drop:1'b0};
    vt[3] = '{m:1, addr:8'h33, wdata:8'h99, we:1'b1, delay:2, sdata:8'hEE, drop:1'b1};
    vt[4] = '{m:0, addr:8'h44, wdata:8'h00, we:1'b0, delay:4, sdata:8'hC3, drop:1'b1};
    vt[5] = '{m:2, addr:8'hFE, wdata:8'h00, we:1'b0, delay:0, sdata:8'h00, drop:1'b0};

    rst_n = 1'b0; m_req = '0; m_addr = '0; m_wdata = '0; m_we = '0;
    bus_ready = 1'b0; bus_rdata = 8'h00;
    repeat (3) @(negedge clk_sys);
    chk("rst_grant", {29'd0, m_grant}, 32'd0);
    chk("rst_ack",   {29'd0, m_ack},   32'd0);
    chk("rst_rdata", {24'd0, m_rdata}, 32'd0);
    chk("rst_err",   {31'd0, m_err},   32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_bus",   {15'd0, bus_addr, bus_wdata, bus_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    mon_en = 1'b1;

    // bus_ready in IDLE must do nothing
    bus_ready = 1'b1; bus_rdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      chk("idle_ready_grant", {29'd0, m_grant}, 32'd0);
      chk("idle_ready_valid", {31'd0, bus_valid}, 32'd0);
    end
    chk("idle_ready_rdata", {24'd0, m_rdata}, 32'd0);
    bus_ready = 1'b0; bus_rdata = 8'h00;
    @(negedge clk_sys);

    for (int i = 0; i < 6; i++) do_xfer(vt[i]);

    // All three requesting with an always-ready slave: strict 0,1,2 rotation, 2 cycles apart
    mon_en = 1'b0;
    m_req = 3'b111; m_we = 3'b000; bus_ready = 1'b1; bus_rdata = 8'h5A;
    for (int c = 0; c < 40 && gq.size() < 6; c++) begin
      @(negedge clk_sys);
      if (m_grant != 3'b000) begin
        gq.push_back(m_grant);
        cq.push_back(c);
        if (gq.size() == 6) m_req = 3'b000;
      end
    end
    @(negedge clk_sys);
    bus_ready = 1'b0; bus_rdata = 8'h00;
    chk("rr_count", gq.size(), 6);
    for (int i = 0; i < gq.size() && i < 6; i++) begin
      logic [2:0] want;
      want = 3'b001 << (i % 3);
      chk("rr_order", {29'd0, gq[i]}, {29'd0, want});
      if (i > 0) chk("rr_spacing", cq[i] - cq[i-1], 2);
    end
    prev_rdata = 8'h5A;
    repeat (2) @(negedge clk_sys);
    mon_en = 1'b1;

    // Slave never answers on master 1
    begin
      exp_t e;
`ifdef BUS_TIMEOUT_EN
      e.ack = 3'b010; e.rdata = 8'hFF; e.err = 1'b1; e.own = 8;
      sb.push_back(e);
      prev_rdata = 8'hFF;
      m_req[1] = 1'b1; m_addr[1] = 8'h66; m_we[1] = 1'b0;
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk_sys);
      chk("tmo_wait", sb.size(), 0);
      m_req[1] = 1'b0;
      @(negedge clk_sys);
      m_req[1] = 1'b1;
      wait_grant(ok);
      chk("grant_wait", {31'd0, ok}, 32'd1);
`else
      e.ack = 3'b000;
      m_req[1] = 1'b1; m_addr[1] = 8'h66; m_we[1] = 1'b0;
      wait_grant(ok);
      chk("grant_wait", {31'd0, ok}, 32'd1);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk_sys);
        chk("stall_grant", {29'd0, m_grant}, 32'd2);
        chk("stall_ack",   {29'd0, m_ack},   {29'd0, e.ack});
      end
`endif
    end

    // Reset during OWN: async clear, no ack, master 0 wins afterwards
    mon_en = 1'b0;
    chk("pre_rst_grant", {29'd0, m_grant}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", {29'd0, m_grant}, 32'd0);
    chk("arst_ack",   {29'd0, m_ack},   32'd0);
    chk("arst_valid", {31'd0, bus_valid}, 32'd0);
    chk("arst_bus",   {15'd0, bus_addr, bus_wdata, bus_we}, 32'd0);
    chk("arst_rdata", {24'd0, m_rdata}, 32'd0);
    chk("arst_err",   {31'd0, m_err},   32'd0);
    m_req = 3'b111;
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    chk("post_rst_grant", {29'd0, m_grant}, 32'd1);
    chk("post_rst_ack",   {29'd0, m_ack},   32'd0);
    @(negedge clk_sys);
    chk("post_rst_ack2",  {29'd0, m_ack},   32'd0);
    m_req = 3'b000;

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
